incubator_ctrl_multi: RTL and testbench
=======================================

# incubator_ctrl_multi

Parametrised successor to the single-setpoint incubator controller: a temperature regulator driving one heater and one multi-speed cooler from a signed sensor sample stream. Sits between the sensor ADC front-end and the actuator drivers. Adds generic sensor width, an N-level cooler speed ladder, per-transition debounce (dwell), a sample-valid qualifier, an enable, and an out-of-range alarm.

## Interface
- W, 8: sensor width, signed two's complement
- LEVELS, 3: cooler speed levels (≥2)
- HEAT_ON, 15: heater engages when sensor < HEAT_ON
- HEAT_OFF, 30: heater releases when sensor > HEAT_OFF
- COOL_ON, 35: cooler engages when sensor > COOL_ON
- COOL_OFF, 25: cooler releases (from level 0) when sensor < COOL_OFF
- STEP, 5: threshold spacing between speed levels
- RPS_W, 4: cooler_rps width
- RPS_BASE, 4 / RPS_STEP, 2: cooler_rps = RPS_BASE + RPS_STEP·level
- DWELL, 1: consecutive qualifying valid samples before a transition commits (≥1)
- ALARM_LO, -10 / ALARM_HI, 60: alarm bounds
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  0 forces IDLE
- sample_valid  in  1  sensor valid this cycle
- sensor  in  W  signed temperature sample
- heater  out  1  heater on
- cooler  out  1  cooler on
- cooler_rps  out  RPS_W  cooler speed, 0 when cooler off
- level  out  LVL_W=$clog2(LEVELS)  current speed level (0 when not cooling)
- alarm  out  1  last valid sample outside [ALARM_LO, ALARM_HI]

## Operation
- States: IDLE, HEAT, COOL (COOL carries level register 0..LEVELS-1).
- Only cycles with sample_valid=1 are evaluated; other cycles hold all state, including the dwell counter.
- Candidate transitions per valid sample (all compares signed, sensor against W-bit-sign-extended thresholds):
  - IDLE: sensor > COOL_ON → COOL level 0; else sensor < HEAT_ON → HEAT.
  - HEAT: sensor > HEAT_OFF → IDLE.
  - COOL level k: k<LEVELS-1 and sensor > COOL_ON+STEP·(k+1) → level k+1; else k>0 and sensor < COOL_ON+STEP·(k-1) → level k-1; else k=0 and sensor < COOL_OFF → IDLE. Up has priority over down.
- Dwell: counter increments on each valid sample whose candidate equals the previous sample's candidate; cleared on valid sample with no candidate, a different candidate, or any commit. Transition commits on the valid sample that makes count = DWELL. DWELL=1 → immediate.
- Outputs: heater=1 iff HEAT; cooler=1 iff COOL; cooler_rps = RPS_BASE+RPS_STEP·level in COOL, else 0.
- alarm updates on every valid sample regardless of enable/state.
- enable=0: next edge forces IDLE, clears level and dwell counter; samples ignored for transitions while low.
- Legal parameters (elaboration-checked): HEAT_ON < HEAT_OFF ≤ COOL_ON; COOL_OFF < COOL_ON; COOL_ON+STEP·(LEVELS-1) ≤ 2^(W-1)-1; RPS_BASE+RPS_STEP·(LEVELS-1) < 2^RPS_W.

## Timing
- All outputs registered; reset value: heater=0, cooler=0, cooler_rps=0, level=0, alarm=0, state IDLE, dwell=0.
- Latency: outputs reflect a commit one cycle after the committing valid sample's edge (visible from the next cycle).
- At most one transition (one level step) per valid sample; a large jump climbs one level per DWELL samples.
- reset and enable=0 override any transition in the same cycle; reset has priority over enable.
- Reset mid-operation: outputs return to reset values at the next edge, no partial transition.
- sample_valid gaps do not break dwell runs.

## Structure
- Package incubator_pkg: state enum (IDLE/HEAT/COOL), threshold function thr(k)=COOL_ON+STEP·k, rps function, parameter legality checks.
- One sub-module natural: incubator_dwell (candidate compare + saturating counter, commit pulse), width $clog2(DWELL+1).

## Test plan
- Defaults, DWELL=1: sensor 20 → 36 → 41 → 46 → outputs cooler=1, rps 4 → 6 → 8, heater=0 throughout.
- From rps 8: sensor 39 → 34 → 24 → rps 6 → 4 → IDLE (cooler=0, rps=0).
- From IDLE: sensor 10 → heater=1; 25 → holds; 31 → heater=0; 14 with sample_valid=0 → no change.
- DWELL=3: sensor 36,36,20,36,36,36 valid → cooler only after sixth sample; valid=0 gaps inserted between runs don't reset count.
- enable dropped while rps 8 → next cycle all outputs 0; reset asserted same cycle as qualifying sample → outputs 0, no transition.
- W=12, LEVELS=5: ramp 36..60 → level 0..4 one step per crossing; sensor 70 → alarm=1; -20 → alarm=1, heater=1.

Source files
------------

// File: rtl/incubator_pkg.sv
// Shared constants and helpers for the multi-level incubator controller:
// state encodings, cooler threshold / speed ladder functions, parameter legality.
package incubator_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAT = 2'd1;
  localparam logic [1:0] ST_COOL = 2'd2;

  // Cooler level k engages above this temperature.
  function automatic int thr(input int cool_on, input int step, input int k);
    return cool_on + step * k;
  endfunction

  function automatic int rps(input int base, input int step, input int lvl);
    return base + step * lvl;
  endfunction

  function automatic bit params_legal(input int w, input int levels,
                                      input int heat_on, input int heat_off,
                                      input int cool_on, input int cool_off,
                                      input int step, input int rps_w,
                                      input int rps_base, input int rps_step,
                                      input int dwell);
    return (levels >= 2) && (dwell >= 1) &&
           (heat_on < heat_off) && (heat_off <= cool_on) &&
           (cool_off < cool_on) &&
           (thr(cool_on, step, levels - 1) <= (1 << (w - 1)) - 1) &&
           (rps(rps_base, rps_step, levels - 1) < (1 << rps_w));
  endfunction

endpackage

// File: rtl/incubator_dwell.sv
// Debounce for controller transitions: counts consecutive valid samples that
// propose the same transition and pulses commit when the run reaches DWELL.
module incubator_dwell #(
  parameter int DWELL = 1,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          valid,
  input  logic          cand_has,
  input  logic [CW-1:0] cand_code,
  output logic          commit
);

  localparam int CNT_W = $clog2(DWELL + 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] next_count;
  logic             prev_has;
  logic [CW-1:0]    prev_code;

  // A repeated candidate extends the run; anything new starts a run of one.
  always_comb begin
    next_count = CNT_W'(1);
    if (prev_has && (prev_code == cand_code))
      next_count = (count == CNT_W'(DWELL)) ? count : count + CNT_W'(1);
    commit = valid && cand_has && (next_count == CNT_W'(DWELL));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count     <= '0;
      prev_has  <= 1'b0;
      prev_code <= '0;
    end else if (valid) begin
      if (!cand_has || commit) begin
        count    <= '0;
        prev_has <= 1'b0;
      end else begin
        count     <= next_count;
        prev_has  <= 1'b1;
        prev_code <= cand_code;
      end
    end
  end

endmodule

// File: rtl/incubator_ctrl_multi.sv
// Heater / multi-speed cooler regulator driven by a qualified signed sensor
// stream, with debounced transitions and an out-of-range alarm.
module incubator_ctrl_multi
  import incubator_pkg::*;
#(
  parameter int W        = 8,
  parameter int LEVELS   = 3,
  parameter int HEAT_ON  = 15,
  parameter int HEAT_OFF = 30,
  parameter int COOL_ON  = 35,
  parameter int COOL_OFF = 25,
  parameter int STEP     = 5,
  parameter int RPS_W    = 4,
  parameter int RPS_BASE = 4,
  parameter int RPS_STEP = 2,
  parameter int DWELL    = 1,
  parameter int ALARM_LO = -10,
  parameter int ALARM_HI = 60
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sample_valid,
  input  logic signed [W-1:0]         sensor,
  output logic                        heater,
  output logic                        cooler,
  output logic [RPS_W-1:0]            cooler_rps,
  output logic [$clog2(LEVELS)-1:0]   level,
  output logic                        alarm
);

  localparam int LVL_W = $clog2(LEVELS);
  localparam int CW    = 2 + LVL_W;

  localparam logic signed [W-1:0] HEAT_ON_T  = W'(HEAT_ON);
  localparam logic signed [W-1:0] HEAT_OFF_T = W'(HEAT_OFF);
  localparam logic signed [W-1:0] COOL_ON_T  = W'(COOL_ON);
  localparam logic signed [W-1:0] COOL_OFF_T = W'(COOL_OFF);
  localparam logic signed [W-1:0] ALARM_LO_T = W'(ALARM_LO);
  localparam logic signed [W-1:0] ALARM_HI_T = W'(ALARM_HI);

  if (!params_legal(W, LEVELS, HEAT_ON, HEAT_OFF, COOL_ON, COOL_OFF, STEP,
                    RPS_W, RPS_BASE, RPS_STEP, DWELL)) begin : g_illegal
    $error("incubator_ctrl_multi: illegal parameter set");
  end

  logic [1:0]             state;
  logic                   cand_has;
  logic [1:0]             cand_state;
  logic [LVL_W-1:0]       cand_level;
  logic signed [W-1:0]    up_thr;
  logic signed [W-1:0]    dn_thr;
  logic                   commit;

  // Transition proposed by the current sample; up beats down in COOL.
  always_comb begin
    up_thr     = W'(thr(COOL_ON, STEP, int'(level) + 1));
    dn_thr     = W'(thr(COOL_ON, STEP, int'(level) - 1));
    cand_has   = 1'b0;
    cand_state = state;
    cand_level = level;
    case (state)
      ST_IDLE: begin
        if (sensor > COOL_ON_T) begin
          cand_has   = 1'b1;
          cand_state = ST_COOL;
          cand_level = '0;
        end else if (sensor < HEAT_ON_T) begin
          cand_has   = 1'b1;
          cand_state = ST_HEAT;
        end
      end
      ST_HEAT: begin
        if (sensor > HEAT_OFF_T) begin
          cand_has   = 1'b1;
          cand_state = ST_IDLE;
        end
      end
      ST_COOL: begin
        if ((int'(level) < LEVELS - 1) && (sensor > up_thr)) begin
          cand_has   = 1'b1;
          cand_level = level + LVL_W'(1);
        end else if ((level != '0) && (sensor < dn_thr)) begin
          cand_has   = 1'b1;
          cand_level = level - LVL_W'(1);
        end else if ((level == '0) && (sensor < COOL_OFF_T)) begin
          cand_has   = 1'b1;
          cand_state = ST_IDLE;
        end
      end
      default: begin
        cand_has   = 1'b1;
        cand_state = ST_IDLE;
        cand_level = '0;
      end
    endcase
  end

  incubator_dwell #(
    .DWELL (DWELL),
    .CW    (CW)
  ) u_dwell (
    .clk       (clk),
    .reset     (reset),
    .clear     (!enable),
    .valid     (sample_valid && enable),
    .cand_has  (cand_has),
    .cand_code ({cand_state, cand_level}),
    .commit    (commit)
  );

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state      <= ST_IDLE;
      level      <= '0;
      heater     <= 1'b0;
      cooler     <= 1'b0;
      cooler_rps <= '0;
    end else if (sample_valid && commit) begin
      state      <= cand_state;
      level      <= (cand_state == ST_COOL) ? cand_level : '0;
      heater     <= (cand_state == ST_HEAT);
      cooler     <= (cand_state == ST_COOL);
      cooler_rps <= (cand_state == ST_COOL) ?
                    RPS_W'(rps(RPS_BASE, RPS_STEP, int'(cand_level))) : '0;
    end
  end

  // Alarm tracks every valid sample, independent of enable and state.
  always_ff @(posedge clk) begin
    if (reset)
      alarm <= 1'b0;
    else if (sample_valid)
      alarm <= (sensor < ALARM_LO_T) || (sensor > ALARM_HI_T);
  end

endmodule

// File: tb/tb_incubator_ctrl_multi.sv
// Scoreboard bench for incubator_ctrl_multi: three configurations (default,
// DWELL=3, W=12/LEVELS=5) driven with directed vectors and hand-computed results.
module tb_incubator_ctrl_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_a, enable_a, valid_a;
  logic signed [7:0] sensor_a;
  logic              heater_a, cooler_a, alarm_a;
  logic [3:0]        rps_a;
  logic [1:0]        level_a;

  logic              reset_b, enable_b, valid_b;
  logic signed [7:0] sensor_b;
  logic              heater_b, cooler_b, alarm_b;
  logic [3:0]        rps_b;
  logic [1:0]        level_b;

  logic               reset_c, enable_c, valid_c;
  logic signed [11:0] sensor_c;
  logic               heater_c, cooler_c, alarm_c;
  logic [3:0]         rps_c;
  logic [2:0]         level_c;

  incubator_ctrl_multi dut_a (
    .clk(clk), .reset(reset_a), .enable(enable_a), .sample_valid(valid_a),
    .sensor(sensor_a), .heater(heater_a), .cooler(cooler_a),
    .cooler_rps(rps_a), .level(level_a), .alarm(alarm_a)
  );

  incubator_ctrl_multi #(.DWELL(3)) dut_b (
    .clk(clk), .reset(reset_b), .enable(enable_b), .sample_valid(valid_b),
    .sensor(sensor_b), .heater(heater_b), .cooler(cooler_b),
    .cooler_rps(rps_b), .level(level_b), .alarm(alarm_b)
  );

  incubator_ctrl_multi #(.W(12), .LEVELS(5)) dut_c (
    .clk(clk), .reset(reset_c), .enable(enable_c), .sample_valid(valid_c),
    .sensor(sensor_c), .heater(heater_c), .cooler(cooler_c),
    .cooler_rps(rps_c), .level(level_c), .alarm(alarm_c)
  );

  typedef struct {
    int    dut;
    int    heater;
    int    cooler;
    int    rps;
    int    level;
    int    alarm;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic pushExpect(input int dut, input int h, input int c, input int r,
                            input int l, input int a, input string name);
    exp_t e;
    e.dut = dut; e.heater = h; e.cooler = c; e.rps = r;
    e.level = l; e.alarm = a; e.name = name;
    exp_q.push_back(e);
  endtask

  // One sample per call; the expectation describes outputs after its edge.
  task automatic applyStimulus(input int dut, input int sensor_v, input bit valid,
                               input bit en, input bit rst,
                               input int h, input int c, input int r,
                               input int l, input int a, input string name);
    @(negedge clk);
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    case (dut)
      0: begin reset_a = rst; enable_a = en; valid_a = valid; sensor_a = 8'(sensor_v); end
      1: begin reset_b = rst; enable_b = en; valid_b = valid; sensor_b = 8'(sensor_v); end
      default: begin reset_c = rst; enable_c = en; valid_c = valid; sensor_c = 12'(sensor_v); end
    endcase
    @(posedge clk);
    pushExpect(dut, h, c, r, l, a, name);
  endtask

  task automatic checkOutput(input exp_t e);
    int ah, ac, ar, al, aa;
    case (e.dut)
      0: begin ah = int'(heater_a); ac = int'(cooler_a); ar = int'(rps_a); al = int'(level_a); aa = int'(alarm_a); end
      1: begin ah = int'(heater_b); ac = int'(cooler_b); ar = int'(rps_b); al = int'(level_b); aa = int'(alarm_b); end
      default: begin ah = int'(heater_c); ac = int'(cooler_c); ar = int'(rps_c); al = int'(level_c); aa = int'(alarm_c); end
    endcase
    checks++;
    if (ah != e.heater || ac != e.cooler || ar != e.rps || al != e.level || aa != e.alarm) begin
      errors++;
      $display("[TB] FAIL %s: got heater=%0d cooler=%0d rps=%0d level=%0d alarm=%0d, expected heater=%0d cooler=%0d rps=%0d level=%0d alarm=%0d",
               e.name, ah, ac, ar, al, aa, e.heater, e.cooler, e.rps, e.level, e.alarm);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_a = 1'b1; enable_a = 1'b1; valid_a = 1'b0; sensor_a = '0;
    reset_b = 1'b1; enable_b = 1'b1; valid_b = 1'b0; sensor_b = '0;
    reset_c = 1'b1; enable_c = 1'b1; valid_c = 1'b0; sensor_c = '0;
    repeat (2) @(posedge clk);
    pushExpect(0, 0, 0, 0, 0, 0, "a_reset");
    pushExpect(1, 0, 0, 0, 0, 0, "b_reset");
    pushExpect(2, 0, 0, 0, 0, 0, "c_reset");

    // Default configuration, immediate transitions.
    applyStimulus(0, 20, 1, 1, 0, 0, 0, 0, 0, 0, "a_idle20");
    applyStimulus(0, 36, 1, 1, 0, 0, 1, 4, 0, 0, "a_cool36");
    applyStimulus(0, 41, 1, 1, 0, 0, 1, 6, 1, 0, "a_up41");
    applyStimulus(0, 46, 1, 1, 0, 0, 1, 8, 2, 0, "a_up46");
    applyStimulus(0, 39, 1, 1, 0, 0, 1, 6, 1, 0, "a_down39");
    applyStimulus(0, 34, 1, 1, 0, 0, 1, 4, 0, 0, "a_down34");
    applyStimulus(0, 24, 1, 1, 0, 0, 0, 0, 0, 0, "a_off24");
    applyStimulus(0, 10, 1, 1, 0, 1, 0, 0, 0, 0, "a_heat10");
    applyStimulus(0, 25, 1, 1, 0, 1, 0, 0, 0, 0, "a_hold25");
    applyStimulus(0, 31, 1, 1, 0, 0, 0, 0, 0, 0, "a_heatoff31");
    applyStimulus(0, 14, 0, 1, 0, 0, 0, 0, 0, 0, "a_novalid14");
    applyStimulus(0, 36, 1, 1, 0, 0, 1, 4, 0, 0, "a_ramp36");
    applyStimulus(0, 41, 1, 1, 0, 0, 1, 6, 1, 0, "a_ramp41");
    applyStimulus(0, 46, 1, 1, 0, 0, 1, 8, 2, 0, "a_ramp46");
    applyStimulus(0, 46, 1, 0, 0, 0, 0, 0, 0, 0, "a_enable_low");
    applyStimulus(0, 36, 1, 1, 0, 0, 1, 4, 0, 0, "a_reenable");
    applyStimulus(0, 41, 1, 1, 1, 0, 0, 0, 0, 0, "a_reset_qual");
    applyStimulus(0, 20, 1, 1, 0, 0, 0, 0, 0, 0, "a_after_reset");
    applyStimulus(0, 61, 1, 0, 0, 0, 0, 0, 0, 1, "a_alarm_disabled");
    applyStimulus(0, 20, 1, 1, 0, 0, 0, 0, 0, 0, "a_alarm_clear");

    // DWELL=3: gaps keep the run, a non-candidate sample breaks it.
    applyStimulus(1, 36, 1, 1, 0, 0, 0, 0, 0, 0, "b_run1");
    applyStimulus(1, 36, 1, 1, 0, 0, 0, 0, 0, 0, "b_run2");
    applyStimulus(1, 20, 1, 1, 0, 0, 0, 0, 0, 0, "b_break");
    applyStimulus(1, 36, 1, 1, 0, 0, 0, 0, 0, 0, "b_rerun1");
    applyStimulus(1, 36, 0, 1, 0, 0, 0, 0, 0, 0, "b_gap1");
    applyStimulus(1, 36, 1, 1, 0, 0, 0, 0, 0, 0, "b_rerun2");
    applyStimulus(1, 36, 0, 1, 0, 0, 0, 0, 0, 0, "b_gap2");
    applyStimulus(1, 36, 1, 1, 0, 0, 1, 4, 0, 0, "b_commit");
    applyStimulus(1, 41, 1, 1, 0, 0, 1, 4, 0, 0, "b_up_run1");
    applyStimulus(1, 41, 1, 1, 0, 0, 1, 4, 0, 0, "b_up_run2");
    applyStimulus(1, 41, 1, 1, 0, 0, 1, 6, 1, 0, "b_up_commit");

    // Wide sensor, five levels, alarm bounds and one-step descent.
    applyStimulus(2, 36, 1, 1, 0, 0, 1, 4, 0, 0, "c_l0");
    applyStimulus(2, 41, 1, 1, 0, 0, 1, 6, 1, 0, "c_l1");
    applyStimulus(2, 46, 1, 1, 0, 0, 1, 8, 2, 0, "c_l2");
    applyStimulus(2, 51, 1, 1, 0, 0, 1, 10, 3, 0, "c_l3");
    applyStimulus(2, 56, 1, 1, 0, 0, 1, 12, 4, 0, "c_l4");
    applyStimulus(2, 60, 1, 1, 0, 0, 1, 12, 4, 0, "c_top60");
    applyStimulus(2, 70, 1, 1, 0, 0, 1, 12, 4, 1, "c_alarm_hi");
    applyStimulus(2, -20, 1, 1, 0, 0, 1, 10, 3, 1, "c_neg_l3");
    applyStimulus(2, -20, 1, 1, 0, 0, 1, 8, 2, 1, "c_neg_l2");
    applyStimulus(2, -20, 1, 1, 0, 0, 1, 6, 1, 1, "c_neg_l1");
    applyStimulus(2, -20, 1, 1, 0, 0, 1, 4, 0, 1, "c_neg_l0");
    applyStimulus(2, -20, 1, 1, 0, 0, 0, 0, 0, 1, "c_neg_idle");
    applyStimulus(2, -20, 1, 1, 0, 1, 0, 0, 0, 1, "c_neg_heat");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
